uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; next generation of the fixed 8N1 transmit datapath.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx_param.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
//   parity_e    : parity mode of a frame (none / even / odd)
//   tx_state_e  : transmitter FSM states
//   IDLE_LEVEL  : level of the serial line between frames
//   parity_bit(): parity bit for a payload given its XOR reduction
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // xor_all is ^payload: even parity sends it as is, odd parity inverts it.
  function automatic logic parity_bit(input parity_e mode, input logic xor_all);
    return (mode == PAR_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk_i    in  clock
//   reset_ni in  asynchronous active-low reset
//   clear_i  in  hold the counter at 0 (no ticks while asserted)
//   div_i    in  clock cycles per bit; 0 behaves as 1
//   tick_o   out high in the last cycle of each bit period
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_max;

  // Terminal count is div_i-1 with an exact compare, so the largest divisor
  // never needs a wrap and div_i of 0 or 1 ticks every cycle.
  assign count_max = (div_i == '0) ? '0 : (div_i - CNT_ONE);
  assign tick_o    = ~clear_i & (count_q == count_max);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-deep holding register.
//   clk_i         in  clock
//   reset_ni      in  asynchronous active-low reset
//   data_i        in  payload to send (DATA_BITS wide)
//   data_valid_i  in  data_i valid
//   data_ready_o  out holding register empty; byte taken on valid & ready
//   baud_div_i    in  clock cycles per bit, sampled at each frame start
//   tx_o          out serial line, idle high
//   busy_o        out a frame is being sent
//   frame_done_o  out one-cycle pulse after the last stop bit
//
// state     | meaning
// ST_IDLE   | line idle, waiting for the holding register to fill
// ST_START  | sending the start bit (low)
// ST_DATA   | sending payload bits, LSB first
// ST_PARITY | sending the parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | sending STOP_BITS stop bits (high)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter parity_e     PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DIV_W-1:0]     baud_div_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int unsigned      BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 hold_full_q;
  logic                 par_q;
  logic                 stop_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DIV_W-1:0]     div_q;

  logic                 tick;
  logic                 accept;
  logic                 last_stop;
  logic                 start_frame;
  logic [DIV_W-1:0]     div_eff;

  assign data_ready_o = ~hold_full_q;
  assign accept       = data_valid_i & ~hold_full_q;
  assign div_eff      = (baud_div_i == '0) ? DIV_ONE : baud_div_i;
  assign last_stop    = (STOP_BITS == 1) | stop_q;

  // A held byte starts a frame from IDLE, or straight out of the final stop
  // tick so consecutive frames have no idle gap.
  assign start_frame = hold_full_q &
                       ((state_q == ST_IDLE) |
                        ((state_q == ST_STOP) & tick & last_stop));

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (state_q == ST_IDLE),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      bit_idx_q    <= '0;
      div_q        <= DIV_ONE;
      tx_o         <= IDLE_LEVEL;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;

      if (accept) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            tx_o    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                tx_o    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_o    <= IDLE_LEVEL;
              end
            end else begin
              bit_idx_q <= bit_idx_q + BIT_ONE;
              shift_q   <= shift_q >> 1;
              tx_o      <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            tx_o    <= IDLE_LEVEL;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (last_stop) begin
              frame_done_o <= 1'b1;
              state_q      <= ST_IDLE;
              busy_o       <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_o    <= IDLE_LEVEL;
          busy_o  <= 1'b0;
        end
      endcase

      // Overrides the IDLE return above when the next byte is already held.
      if (start_frame) begin
        state_q     <= ST_START;
        tx_o        <= ~IDLE_LEVEL;
        busy_o      <= 1'b1;
        shift_q     <= hold_q;
        par_q       <= parity_bit(PARITY, ^hold_q);
        hold_full_q <= 1'b0;
        bit_idx_q   <= '0;
        stop_q      <= 1'b0;
        div_q       <= div_eff;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  data_d  [4];
  logic        valid_d [4];
  logic [15:0] baud_d  [4];
  logic        tx      [4];
  logic        ready   [4];
  logic        busy    [4];
  logic        done    [4];

  int n_pass  = 0;
  int n_total = 0;

  // Configurations of the four instances: 8N1, 8E1, 8O1, 5N2.
  int cfg_db  [4] = '{8, 8, 8, 5};
  int cfg_par [4] = '{0, 1, 2, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};
  string sig_names [4] = '{"tx", "ready", "busy", "frame_done"};

  int   seq_bytes[$];
  logic cap_tx[$], cap_rdy[$], cap_busy[$], cap_done[$];
  logic e_tx[$],   e_rdy[$],   e_busy[$],   e_done[$];
  int   first_diff;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(uart_pkg::PAR_NONE), .STOP_BITS(1), .DIV_W(16)) u_8n1 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data_d[0][7:0]), .data_valid_i(valid_d[0]),
    .data_ready_o(ready[0]), .baud_div_i(baud_d[0]), .tx_o(tx[0]), .busy_o(busy[0]),
    .frame_done_o(done[0]));

  uart_tx_param #(.DATA_BITS(8), .PARITY(uart_pkg::PAR_EVEN), .STOP_BITS(1), .DIV_W(16)) u_8e1 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data_d[1][7:0]), .data_valid_i(valid_d[1]),
    .data_ready_o(ready[1]), .baud_div_i(baud_d[1]), .tx_o(tx[1]), .busy_o(busy[1]),
    .frame_done_o(done[1]));

  uart_tx_param #(.DATA_BITS(8), .PARITY(uart_pkg::PAR_ODD), .STOP_BITS(1), .DIV_W(16)) u_8o1 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data_d[2][7:0]), .data_valid_i(valid_d[2]),
    .data_ready_o(ready[2]), .baud_div_i(baud_d[2]), .tx_o(tx[2]), .busy_o(busy[2]),
    .frame_done_o(done[2]));

  uart_tx_param #(.DATA_BITS(5), .PARITY(uart_pkg::PAR_NONE), .STOP_BITS(2), .DIV_W(16)) u_5n2 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data_d[3][4:0]), .data_valid_i(valid_d[3]),
    .data_ready_o(ready[3]), .baud_div_i(baud_d[3]), .tx_o(tx[3]), .busy_o(busy[3]),
    .frame_done_o(done[3]));

  // ---------------- reference model ----------------
  function automatic int frame_bits(input int id);
    return 1 + cfg_db[id] + ((cfg_par[id] != 0) ? 1 : 0) + cfg_sb[id];
  endfunction

  // Line level during bit position pos of a frame carrying b.
  function automatic logic line_level(input int id, input int b, input int pos);
    int payload;
    int ones;
    payload = b & ((1 << cfg_db[id]) - 1);
    ones    = $countones(payload);
    if (pos == 0) return 1'b0;
    if (pos <= cfg_db[id]) return ((payload >> (pos - 1)) & 1) != 0;
    if (cfg_par[id] != 0 && pos == cfg_db[id] + 1)
      return (cfg_par[id] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  // Sends seq_bytes on instance id with valid held until all are taken.
  // baud is div_a for the first frame and switches to div_b three samples
  // into it. Captures all outputs at negedges and builds expected traces:
  // sample 0 precedes the first handshake edge, frame 0 starts at sample 2,
  // each later frame starts exactly when the previous one ends.
  task automatic run_seq(input int id, input int div_a, input int div_b);
    int n, total, idx;
    int s[$], len[$], eff[$];
    bit pend;
    n = seq_bytes.size();
    for (int i = 0; i < n; i++) begin
      int d;
      d = (i == 0) ? div_a : div_b;
      eff.push_back((d == 0) ? 1 : d);
      len.push_back(frame_bits(id) * eff[i]);
      s.push_back((i == 0) ? 2 : s[i-1] + len[i-1]);
    end
    total = s[n-1] + len[n-1] + 3;
    e_tx.delete(); e_rdy.delete(); e_busy.delete(); e_done.delete();
    cap_tx.delete(); cap_rdy.delete(); cap_busy.delete(); cap_done.delete();
    for (int j = 0; j < total; j++) begin
      e_tx.push_back(1'b1); e_rdy.push_back(1'b1);
      e_busy.push_back(1'b0); e_done.push_back(1'b0);
    end
    for (int i = 0; i < n; i++) begin
      int a;
      for (int c = 0; c < len[i]; c++) begin
        e_tx[s[i] + c]   = line_level(id, seq_bytes[i], c / eff[i]);
        e_busy[s[i] + c] = 1'b1;
      end
      e_done[s[i] + len[i]] = 1'b1;
      a = (i == 0) ? 1 : s[i-1] + 1;
      for (int j = a; j < s[i]; j++) e_rdy[j] = 1'b0;
    end

    @(negedge clk);
    baud_d[id]  = 16'(div_a);
    data_d[id]  = 9'(seq_bytes[0]);
    valid_d[id] = 1'b1;
    idx  = 0;
    pend = 1'b0;
    for (int j = 0; j < total; j++) begin
      if (pend) begin
        idx++;
        if (idx < n) data_d[id] = 9'(seq_bytes[idx]);
        else valid_d[id] = 1'b0;
      end
      if (j == s[0] + 3) baud_d[id] = 16'(div_b);
      cap_tx.push_back(tx[id]);
      cap_rdy.push_back(ready[id]);
      cap_busy.push_back(busy[id]);
      cap_done.push_back(done[id]);
      pend = valid_d[id] && ready[id];
      @(negedge clk);
    end
    valid_d[id] = 1'b0;
  endtask

  function automatic int diff_count(input int k);
    int d;
    d = 0;
    first_diff = -1;
    for (int j = 0; j < cap_tx.size(); j++) begin
      logic g, e;
      g = 1'b0;
      e = 1'b0;
      case (k)
        0: begin g = cap_tx[j];   e = e_tx[j];   end
        1: begin g = cap_rdy[j];  e = e_rdy[j];  end
        2: begin g = cap_busy[j]; e = e_busy[j]; end
        default: begin g = cap_done[j]; e = e_done[j]; end
      endcase
      if (g !== e) begin
        if (d == 0) first_diff = j;
        d++;
      end
    end
    return d;
  endfunction

  function automatic int high_count(input int k, input int from, input int upto);
    int c;
    c = 0;
    for (int j = from; j < upto && j < cap_tx.size(); j++) begin
      case (k)
        0: if (cap_tx[j] === 1'b1) c++;
        1: if (cap_rdy[j] === 1'b1) c++;
        2: if (cap_busy[j] === 1'b1) c++;
        default: if (cap_done[j] === 1'b1) c++;
      endcase
    end
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_total++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1)
      $display("FAIL reset_held: tx=%b ready=%b, want tx=1 ready=1", tx[0], ready[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      n_total++;
      if (tx[id] !== 1'b1) $display("FAIL reset_tx[%0d]: got %b want 1", id, tx[id]); else n_pass++;
      n_total++;
      if (ready[id] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", id, ready[id]); else n_pass++;
      n_total++;
      if (busy[id] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", id, busy[id]); else n_pass++;
      n_total++;
      if (done[id] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", id, done[id]); else n_pass++;
    end
  endtask

  task automatic test_8n1;
    int d;
    logic exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    seq_bytes = '{'hA5};
    run_seq(0, 4, 4);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      d = diff_count(k);
      if (d != 0) $display("FAIL 8n1_%s: %0d samples differ (first %0d), want 0", sig_names[k], d, first_diff);
      else n_pass++;
    end
    // Mid-bit samples of 0xA5: start, 1,0,1,0,0,1,0,1, stop.
    for (int b = 0; b < 10; b++) begin
      n_total++;
      if (cap_tx[2 + 4*b + 2] !== exp_bits[b])
        $display("FAIL 8n1_bit%0d: got %b want %b", b, cap_tx[2 + 4*b + 2], exp_bits[b]);
      else n_pass++;
    end
    n_total++;
    d = high_count(3, 0, cap_done.size());
    if (d != 1) $display("FAIL 8n1_done_count: got %0d want 1", d); else n_pass++;
  endtask

  task automatic test_parity;
    int d;
    logic want;
    for (int id = 1; id <= 2; id++) begin
      seq_bytes = '{'h07};
      run_seq(id, 2, 2);
      for (int k = 0; k < 4; k++) begin
        n_total++;
        d = diff_count(k);
        if (d != 0) $display("FAIL parity%0d_%s: %0d samples differ (first %0d), want 0", id, sig_names[k], d, first_diff);
        else n_pass++;
      end
      want = (id == 1) ? 1'b1 : 1'b0;
      n_total++;
      if (cap_tx[2 + 9*2 + 1] !== want)
        $display("FAIL parity%0d_bit: got %b want %b", id, cap_tx[2 + 9*2 + 1], want);
      else n_pass++;
      n_total++;
      d = high_count(2, 0, cap_busy.size());
      if (d != 22) $display("FAIL parity%0d_frame_len: got %0d want 22", id, d); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int d;
    seq_bytes = '{'h55, 'hAA};
    run_seq(0, 2, 2);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      d = diff_count(k);
      if (d != 0) $display("FAIL b2b_%s: %0d samples differ (first %0d), want 0", sig_names[k], d, first_diff);
      else n_pass++;
    end
    n_total++;
    if (cap_tx[22] !== 1'b0 || cap_done[22] !== 1'b1)
      $display("FAIL b2b_second_start: tx=%b done=%b, want tx=0 done=1", cap_tx[22], cap_done[22]);
    else n_pass++;
    n_total++;
    d = cap_rdy.size() - high_count(1, 0, cap_rdy.size());
    if (d != 20) $display("FAIL b2b_ready_low: got %0d cycles want 20", d); else n_pass++;
    n_total++;
    d = high_count(2, 0, cap_busy.size());
    if (d != 40) $display("FAIL b2b_busy_len: got %0d want 40", d); else n_pass++;
  endtask

  task automatic test_stop2;
    int d;
    seq_bytes = '{'h1FF};
    run_seq(3, 3, 3);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      d = diff_count(k);
      if (d != 0) $display("FAIL stop2_%s: %0d samples differ (first %0d), want 0", sig_names[k], d, first_diff);
      else n_pass++;
    end
    n_total++;
    d = high_count(0, 2 + 18, 2 + 24);
    if (d != 6) $display("FAIL stop2_stop_high: got %0d want 6", d); else n_pass++;
    n_total++;
    d = high_count(2, 0, cap_busy.size());
    if (d != 24) $display("FAIL stop2_frame_len: got %0d want 24", d); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    @(negedge clk);
    baud_d[0]  = 16'd3;
    data_d[0]  = 9'h03C;
    valid_d[0] = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1 || ready[0] !== 1'b0)
      $display("FAIL rstmid_pre: tx=%b busy=%b ready=%b, want 0 1 0", tx[0], busy[0], ready[0]);
    else n_pass++;
    #2;
    rst_n      = 1'b0;
    valid_d[0] = 1'b0;
    #1;
    n_total++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL rstmid_async: tx=%b ready=%b busy=%b, want 1 1 0", tx[0], ready[0], busy[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1 || done[0] !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rstmid_idle_after: %0d non-idle cycles, want 0", bad); else n_pass++;
  endtask

  task automatic test_baud_div;
    int d;
    seq_bytes = '{'h81, 'h3C};
    run_seq(0, 0, 3);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      d = diff_count(k);
      if (d != 0) $display("FAIL div_%s: %0d samples differ (first %0d), want 0", sig_names[k], d, first_diff);
      else n_pass++;
    end
    n_total++;
    if (cap_done[12] !== 1'b1 || cap_done[42] !== 1'b1)
      $display("FAIL div_done_pos: done@12=%b done@42=%b, want 1 1", cap_done[12], cap_done[42]);
    else n_pass++;
  endtask

  task automatic test_random;
    int d, n;
    for (int id = 0; id < 4; id++) begin
      for (int r = 0; r < 3; r++) begin
        seq_bytes.delete();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) seq_bytes.push_back($urandom_range(0, 511));
        run_seq(id, $urandom_range(0, 5), $urandom_range(0, 5));
        for (int k = 0; k < 4; k++) begin
          n_total++;
          d = diff_count(k);
          if (d != 0)
            $display("FAIL rand_i%0d_r%0d_%s: %0d samples differ (first %0d), want 0", id, r, sig_names[k], d, first_diff);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int id = 0; id < 4; id++) begin
      data_d[id]  = '0;
      valid_d[id] = 1'b0;
      baud_d[id]  = 16'd1;
    end
    test_reset;
    test_8n1;
    test_parity;
    test_back_to_back;
    test_stop2;
    test_reset_mid_frame;
    test_baud_div;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
